// File: rtl/alu_serial_if.sv
// alu_serial_if: request/response bundle for the bit-serial ALU.
// The master drives start/operands; the slave returns status and result.
interface alu_serial_if;
   logic        start;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [3:0]  ALU_control;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        cout;
   logic        overflow;

   modport master (
      output start, src1, src2, ALU_control,
      input  busy, done, result, zero, cout, overflow
   );

   modport slave (
      input  start, src1, src2, ALU_control,
      output busy, done, result, zero, cout, overflow
   );
endinterface

// File: rtl/alu_serial.sv
// alu_serial: bit-serial 32-bit ALU, one slice per clock, LSB first.
// Fixed 34-cycle latency from accept to the done pulse.
module alu_serial (
   input  logic         clk,
   input  logic         rst_n,
   alu_serial_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   state_t      state;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [3:0]  ctl_q;
   logic [4:0]  cnt;
   logic        carry;
   logic [31:0] sreg;
   logic        set_q;
   logic        msb_cin;
   logic        msb_cout;
   logic        busy_q;
   logic        done_q;
   logic [31:0] result_q;
   logic        zero_q;
   logic        cout_q;
   logic        ovf_q;

   logic        a_bit;
   logic        b_bit;
   logic        sum;
   logic        cnext;
   logic        slice_out;
   logic [31:0] fix_res;

   // one ALU slice on bit cnt; LESS emits 0 here, bit 0 is patched later
   always_comb begin
      a_bit     = a_q[cnt] ^ ctl_q[3];
      b_bit     = b_q[cnt] ^ ctl_q[2];
      sum       = a_bit ^ b_bit ^ carry;
      cnext     = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
      slice_out = 1'b0;
      case (ctl_q[1:0])
         2'b00:   slice_out = a_bit & b_bit;
         2'b01:   slice_out = a_bit | b_bit;
         2'b10:   slice_out = sum;
         default: slice_out = 1'b0;
      endcase
   end

   // final result: SLT takes the raw sign of the difference into bit 0
   always_comb begin
      fix_res = sreg;
      if (ctl_q[1:0] == 2'b11) begin
         fix_res[0] = set_q;
      end
   end

   // control FSM, datapath shift register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctl_q    <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         sreg     <= '0;
         set_q    <= 1'b0;
         msb_cin  <= 1'b0;
         msb_cout <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q    <= bus.src1;
                  b_q    <= bus.src2;
                  ctl_q  <= bus.ALU_control;
                  cnt    <= '0;
                  carry  <= bus.ALU_control[2];
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sreg  <= {slice_out, sreg[31:1]};
               carry <= cnext;
               if (cnt == 5'd31) begin
                  set_q    <= sum;
                  msb_cin  <= carry;
                  msb_cout <= cnext;
                  state    <= FIX;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            FIX: begin
               result_q <= fix_res;
               zero_q   <= (fix_res == 32'd0);
               cout_q   <= (ctl_q[1:0] == 2'b10) & msb_cout;
               ovf_q    <= ctl_q[1] & (msb_cin ^ msb_cout);
               done_q   <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vectors with a queue scoreboard.
// Stimulus pushes expectations; a monitor pops them on done.
module tb_alu_serial;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   exp_t sb[$];

   alu_serial_if bus ();

   alu_serial dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // monitor: every done must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h expected none",
                     bus.result);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_res"}, bus.result, e.res);
            chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.z));
            chk({e.name, "_cout"}, 32'(bus.cout), 32'(e.c));
            chk({e.name, "_ovf"}, 32'(bus.overflow), 32'(e.v));
            chk({e.name, "_lat"}, 32'(cyc), 32'(e.acc + 34));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) chk("idle_timeout", 32'(bus.busy), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic run_op(string nm, logic [3:0] ctl,
                         logic [31:0] a, logic [31:0] b,
                         logic [31:0] r, logic z, logic c, logic v);
      exp_t e;
      wait_idle();
      bus.start       = 1'b1;
      bus.ALU_control = ctl;
      bus.src1        = a;
      bus.src2        = b;
      e.name = nm;
      e.res  = r;
      e.z    = z;
      e.c    = c;
      e.v    = v;
      e.acc  = cyc;
      sb.push_back(e);
      @(negedge clk);
      bus.start       = 1'b0;
      bus.ALU_control = ~ctl;
      bus.src1        = ~a;
      bus.src2        = a ^ b;
   endtask

   initial begin
      exp_t        e;
      int          acc_t[3];
      int          pushes;
      int          n;
      int          d0;
      logic [32:0] s;
      bus.start       = 1'b0;
      bus.src1        = '0;
      bus.src2        = '0;
      bus.ALU_control = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1,
             32'h80000000, 0, 0, 1);
      drain();
      repeat (3) @(negedge clk);
      chk("hold_result", bus.result, 32'h80000000);
      chk("hold_ovf", 32'(bus.overflow), 32'd1);

      run_op("sub_eq", 4'b0110, 32'd5, 32'd5, 32'h0, 1, 1, 0);
      run_op("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h1,
             32'h1, 0, 0, 0);
      run_op("slt_pos", 4'b0111, 32'd3, 32'd2, 32'h0, 1, 0, 0);
      run_op("slt_raw", 4'b0111, 32'h80000000, 32'h1,
             32'h0, 1, 0, 1);
      run_op("nor", 4'b1100, 32'hF0F0F0F0, 32'h0F0F0F0F,
             32'h0, 1, 0, 0);
      run_op("or", 4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F,
             32'hFFFFFFFF, 0, 0, 0);
      run_op("and", 4'b0000, 32'hFFFF0000, 32'h0F0F0F0F,
             32'h0F0F0000, 0, 0, 0);
      run_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1,
             32'h0, 1, 1, 0);
      drain();

      // start held high, operands changing every cycle
      wait_idle();
      d0 = n_done;
      pushes = 0;
      n = 0;
      bus.ALU_control = 4'b0010;
      bus.start = 1'b1;
      while (pushes < 3 && n < 200) begin
         bus.src1 = 32'(cyc) * 32'h9E3779B9;
         bus.src2 = ~(32'(cyc) << 3);
         if (!bus.busy) begin
            s = {1'b0, bus.src1} + {1'b0, bus.src2};
            e.name = $sformatf("cont%0d", pushes);
            e.res  = s[31:0];
            e.z    = (s[31:0] == 32'd0);
            e.c    = s[32];
            e.v    = (bus.src1[31] == bus.src2[31]) &&
                     (s[31] != bus.src1[31]);
            e.acc  = cyc;
            sb.push_back(e);
            acc_t[pushes] = cyc;
            pushes++;
         end
         if (pushes < 3) begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk("cont_accepts", 32'(pushes), 32'd3);
      drain();
      chk("cont_dones", 32'(n_done - d0), 32'd3);
      chk("cont_period1", 32'(acc_t[1] - acc_t[0]), 32'd35);
      chk("cont_period2", 32'(acc_t[2] - acc_t[1]), 32'd35);

      // reset in the middle of an ADD aborts it
      wait_idle();
      bus.ALU_control = 4'b0010;
      bus.src1  = 32'h12345678;
      bus.src2  = 32'h11111111;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      d0 = n_done;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_result", bus.result, 32'd0);
      chk("abort_zero", 32'(bus.zero), 32'd0);
      chk("abort_cout", 32'(bus.cout), 32'd0);
      chk("abort_ovf", 32'(bus.overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 32'(n_done - d0), 32'd0);

      run_op("add_after_rst", 4'b0010, 32'd1, 32'd2, 32'd3, 0, 0, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
